ysyx_22040127_alu_mdu: RTL and testbench

//  Parametrised execute-stage arithmetic unit: RV64I ALU ops plus RV64M multiply/divide.

---
 rtl/ysyx_22040127_alu_mdu.sv | 158 +++++++++++++++
 tb/tb_ysyx_22040127_alu_mdu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040127_alu_mdu.sv
// rtl/ysyx_22040127_alu_mdu.sv - RV64IM execute unit: single-cycle ALU ops, iterative mul/div
module ysyx_22040127_alu_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam int CW = $clog2(XLEN) + 1;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    r[31:0] = v;
    return r;
  endfunction

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod, mcand;
  logic [XLEN-1:0]   mplier, rem, quo, dvsr;
  logic              neg_res, neg_rem, k_word, k_hi, k_rem;

  logic              accept, is_mul, is_div, is_rem, wd, sgn1, sgn2, neg1, neg2;
  logic              div_zero, div_ovf;
  logic [5:0]        shamt;
  logic [CW-1:0]     iters;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, min_val, alu_raw, quick;
  logic [2*XLEN-1:0] prod_nx, prod_fin;
  logic [XLEN:0]     r_sh, diff;
  logic [XLEN-1:0]   rem_nx, quo_nx, q_fin, r_fin, fin;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Request decode: operand extension, magnitudes and the div special cases.
  always_comb begin
    is_mul   = (op >= 5'd10) && (op <= 5'd13);
    is_div   = (op >= 5'd14) && (op <= 5'd17);
    is_rem   = (op == 5'd16) || (op == 5'd17);
    wd       = word && (XLEN == 64) &&
               (op inside {5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd10, 5'd14, 5'd15, 5'd16, 5'd17});
    sgn1     = (op == 5'd11) || (op == 5'd12) || (op == 5'd14) || (op == 5'd16);
    sgn2     = (op == 5'd11) || (op == 5'd14) || (op == 5'd16);
    a_ext    = wd ? (sgn1 ? sext32(src1[31:0]) : zext32(src1[31:0])) : src1;
    b_ext    = wd ? (sgn2 ? sext32(src2[31:0]) : zext32(src2[31:0])) : src2;
    neg1     = sgn1 & a_ext[XLEN-1];
    neg2     = sgn2 & b_ext[XLEN-1];
    mag_a    = neg1 ? -a_ext : a_ext;
    mag_b    = neg2 ? -b_ext : b_ext;
    iters    = wd ? CW'(32) : CW'(XLEN);
    min_val  = wd ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    div_ovf  = is_div && sgn2 && (a_ext == min_val) && (&b_ext);
    shamt    = ((XLEN == 64) && !wd) ? src2[5:0] : {1'b0, src2[4:0]};

    case (op)
      5'd0:    alu_raw = src1 + src2;
      5'd1:    alu_raw = src1 - src2;
      5'd2:    alu_raw = src1 << shamt;
      5'd3:    alu_raw = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      5'd4:    alu_raw = {{(XLEN-1){1'b0}}, src1 < src2};
      5'd5:    alu_raw = src1 ^ src2;
      5'd6:    alu_raw = (wd ? zext32(src1[31:0]) : src1) >> shamt;
      5'd7:    alu_raw = $signed(wd ? sext32(src1[31:0]) : src1) >>> shamt;
      5'd8:    alu_raw = src1 | src2;
      5'd9:    alu_raw = src1 & src2;
      default: alu_raw = '0;
    endcase

    if (is_div) begin
      if (div_zero) quick = is_rem ? a_ext : '1;
      else          quick = is_rem ? '0 : a_ext;
    end else begin
      quick = alu_raw;
    end
    if (wd) quick = sext32(quick[31:0]);
  end

  // One shift-add / restore-subtract step, plus sign fix-up for the final step.
  always_comb begin
    prod_nx  = prod + (mplier[0] ? mcand : '0);
    r_sh     = {rem, quo[XLEN-1]};
    diff     = r_sh - {1'b0, dvsr};
    rem_nx   = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_nx   = {quo[XLEN-2:0], ~diff[XLEN]};
    prod_fin = neg_res ? -prod_nx : prod_nx;
    q_fin    = neg_res ? -quo_nx : quo_nx;
    r_fin    = neg_rem ? -rem_nx : rem_nx;
    if (state == MUL) fin = k_hi ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
    else              fin = k_rem ? r_fin : q_fin;
    if (k_word) fin = sext32(fin[31:0]);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= IDLE;
      result <= '0;
      cnt    <= '0;
    end else if (accept) begin
      k_word  <= wd;
      k_hi    <= (op != 5'd10);
      k_rem   <= is_rem;
      neg_res <= neg1 ^ neg2;
      neg_rem <= neg1;
      cnt     <= iters;
      prod    <= '0;
      mcand   <= {{XLEN{1'b0}}, mag_a};
      mplier  <= mag_b;
      rem     <= '0;
      // Word divides start with the 32-bit dividend in the top half so 32 steps suffice.
      quo     <= wd ? (mag_a << 32) : mag_a;
      dvsr    <= mag_b;
      if (is_mul) begin
        state <= MUL;
      end else if (is_div && !div_zero && !div_ovf) begin
        state <= DIV;
      end else begin
        state  <= DONE;
        result <= quick;
      end
    end else if (state == DONE) begin
      if (out_ready) state <= IDLE;
    end else if (state != IDLE) begin
      prod   <= prod_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_nx;
      quo    <= quo_nx;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state  <= DONE;
        result <= fin;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22040127_alu_mdu.sv
// tb/tb_ysyx_22040127_alu_mdu.sv - scoreboard bench with randomized ops and a 128-bit arithmetic model
module tb_ysyx_22040127_alu_mdu;
  logic        clk = 0;
  logic        rst, flush, in_valid, in_ready, word, out_valid, out_ready;
  logic [4:0]  op;
  logic [63:0] src1, src2, result;
  logic        rdy_rand = 0, rdy_force = 1, rnd_rdy = 1;
  int          total = 0, bad = 0, cycle = 0;
  bit          lat_done = 0;

  typedef struct {
    logic [63:0] exp;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  assign out_ready = rdy_rand ? rnd_rdy : rdy_force;

  ysyx_22040127_alu_mdu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;
  always @(negedge clk) rnd_rdy = ($urandom_range(0, 3) != 0);

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic bit is_wop(input logic [4:0] o, input logic w);
    return w && (o inside {5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd10, 5'd14, 5'd15, 5'd16, 5'd17});
  endfunction

  function automatic logic [63:0] model(input logic [4:0] o, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    longint            sa, sb2;
    int                a32, b32;
    logic signed [127:0] x, y;
    logic [127:0]      p, ua, ub;
    logic [31:0]       r32;
    bit                ovf32, ovf64;
    sa = a; sb2 = b; a32 = a[31:0]; b32 = b[31:0];
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    r32 = 0;
    if (is_wop(o, w)) begin
      case (o)
        5'd0:  r32 = a32 + b32;
        5'd1:  r32 = a32 - b32;
        5'd2:  r32 = a[31:0] << b[4:0];
        5'd6:  r32 = a[31:0] >> b[4:0];
        5'd7:  r32 = a32 >>> b[4:0];
        5'd10: r32 = a32 * b32;
        5'd14: if (b32 == 0) r32 = 32'hFFFF_FFFF; else if (ovf32) r32 = a[31:0]; else r32 = a32 / b32;
        5'd15: if (b32 == 0) r32 = 32'hFFFF_FFFF; else r32 = a[31:0] / b[31:0];
        5'd16: if (b32 == 0) r32 = a[31:0]; else if (ovf32) r32 = 0; else r32 = a32 % b32;
        default: if (b32 == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
      endcase
      return sx(r32);
    end
    case (o)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a << b[5:0];
      5'd3: return {63'b0, sa < sb2};
      5'd4: return {63'b0, a < b};
      5'd5: return a ^ b;
      5'd6: return a >> b[5:0];
      5'd7: return sa >>> b[5:0];
      5'd8: return a | b;
      5'd9: return a & b;
      5'd10: return a * b;
      5'd11: begin x = sa; y = sb2; p = x * y; return p[127:64]; end
      5'd12: begin x = sa; y = {64'b0, b}; p = x * y; return p[127:64]; end
      5'd13: begin ua = {64'b0, a}; ub = {64'b0, b}; p = ua * ub; return p[127:64]; end
      5'd14: begin if (b == 0) return '1; if (ovf64) return a; return sa / sb2; end
      5'd15: begin if (b == 0) return '1; return a / b; end
      5'd16: begin if (b == 0) return a; if (ovf64) return 0; return sa % sb2; end
      5'd17: begin if (b == 0) return a; return a % b; end
      default: return 0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    int n;
    bit wo, zero, ovf;
    wo = is_wop(o, w);
    n = wo ? 32 : 64;
    if (o >= 5'd10 && o <= 5'd13) return n + 1;
    if (o >= 5'd14 && o <= 5'd17) begin
      zero = wo ? (b[31:0] == 0) : (b == 0);
      ovf  = (o == 5'd14 || o == 5'd16) &&
             (wo ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                 : (a == 64'h8000_0000_0000_0000 && b == '1));
      return (zero || ovf) ? 1 : n + 1;
    end
    return 1;
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return {56'h0, 8'($urandom)};
      5: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic issue(input logic [4:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input bit b2b, input logic [63:0] exp);
    int   waits;
    exp_t e;
    waits = 0;
    @(negedge clk);
    if (b2b) rdy_force = 1;
    in_valid = 1; op = o; word = w; src1 = a; src2 = b;
    #1;
    if (b2b) check("b2b_in_ready", {63'b0, in_ready}, 64'd1);
    while (!in_ready && waits < 300) begin
      @(negedge clk); #1; waits++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=busy required=ready");
      in_valid = 0;
      return;
    end
    e.exp = exp; e.acc = cycle + 1; e.lat = exp_lat(o, w, a, b);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 0; src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: checks latency on first sight of out_valid, result on handshake.
  always @(negedge clk) begin
    #2;
    if (rst || flush) begin
      sb.delete();
      lat_done = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL stray_out_valid got=%h required=none", result);
      end else begin
        if (!lat_done) begin
          total++;
          if (cycle - sb[0].acc + 1 != sb[0].lat) begin
            bad++;
            $display("FAIL latency got=%0d required=%0d", cycle - sb[0].acc + 1, sb[0].lat);
          end
          lat_done = 1;
        end
        if (out_ready) begin
          total++;
          if (result !== sb[0].exp) begin
            bad++;
            $display("FAIL result got=%h required=%h", result, sb[0].exp);
          end
          void'(sb.pop_front());
          lat_done = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;
    int          n;
    rst = 1; flush = 0; in_valid = 0; op = 0; word = 0; src1 = 0; src2 = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #3;
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);
    check("reset_result", result, 64'd0);

    issue(5'd0, 1, 64'h7FFF_FFFF, 64'd1, 0, 64'hFFFF_FFFF_8000_0000);
    issue(5'd13, 0, '1, '1, 0, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(5'd10, 0, '1, '1, 0, 64'h1);
    issue(5'd14, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(5'd16, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(5'd14, 1, 64'd100, 64'd7, 0, 64'd14);
    issue(5'd15, 0, 64'h1234, 64'd0, 0, '1);
    issue(5'd16, 0, 64'h8000_0000_0000_0000, '1, 0, 64'd0);
    wait_drain(500);

    rdy_force = 0;
    issue(5'd0, 0, 64'd5, 64'd6, 0, 64'd11);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk); #3; n++;
    end
    repeat (5) begin
      @(negedge clk); #3;
      check("hold_result", result, 64'd11);
      check("hold_in_ready", {63'b0, in_ready}, 64'd0);
    end
    issue(5'd8, 0, 64'hF0, 64'h0F, 1, 64'hFF);
    wait_drain(100);

    issue(5'd14, 0, 64'd1000, 64'd3, 0, 64'd333);
    repeat (9) @(negedge clk);
    flush = 1; in_valid = 1; op = 5'd0; word = 0; src1 = 64'd1; src2 = 64'd2;
    @(negedge clk);
    flush = 0; in_valid = 0;
    #3;
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    check("flush_result", result, 64'd0);
    repeat (3) @(negedge clk);
    check("flush_idle", {63'b0, out_valid}, 64'd0);
    issue(5'd7, 0, 64'h8000_0000_0000_0000, 64'd63, 0, '1);
    wait_drain(100);

    rdy_rand = 1;
    for (int i = 0; i < 200; i++) begin
      ro = 5'($urandom_range(0, 17));
      rw = 1'($urandom_range(0, 1));
      ra = rnd_opnd();
      rb = rnd_opnd();
      issue(ro, rw, ra, rb, 0, model(ro, rw, ra, rb));
    end
    wait_drain(1000);
    rdy_rand = 0; rdy_force = 1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
